// File: rtl/dvp_stream_gen.sv
// ---------------------------------------------------------------------------
// dvp_stream_gen
//
// On-chip DVP camera imitator. Produces VSYNC/HREF frame timing and
// YCbCr422-style byte streams for NUM_CH sensors that share one timing.
// It stands in for the sensor pads so the capture, HDR-merge and DDR paths
// can be exercised in hardware without an external camera.
//
// Frame sequence: IDLE -> VS -> VFP -> LINE (V_ACTIVE lines) -> VBP -> VS ...
//
// Ports:
//   pclk        pixel clock
//   reset_n     asynchronous active-low reset
//   run_test    one-cycle start pulse (ignored while busy)
//   stop_test   one-cycle graceful stop request (current frame completes)
//   mode        pattern: 0 ramp, 1 line index, 2 frame-scrolled ramp, 3 constant
//   VSYNC       frame sync, active high
//   HREF        line valid
//   D           NUM_CH*DW data, channel k at D[k*DW +: DW], zero when HREF=0
//   busy        high whenever the generator is not idle
//   frame_cnt   frames completed since the last accepted run_test
//   frame_done  one-cycle pulse in the last cycle of every frame
//
// Optional feature macro: DVP_IMIT_LINE_TAG_EN
//   When defined, bytes 0 and 1 of every line carry the line index
//   (high byte, then low byte) on all channels, overriding the pattern.
// ---------------------------------------------------------------------------
module dvp_stream_gen #(
   parameter int unsigned     H_ACTIVE  = 1280,
   parameter int unsigned     H_TOTAL   = 5688,
   parameter int unsigned     V_ACTIVE  = 720,
   parameter int unsigned     VSYNC_LEN = 11376,
   parameter int unsigned     V_FRONT   = 976,
   parameter int unsigned     V_BACK    = 5688,
   parameter int unsigned     NUM_CH    = 2,
   parameter int unsigned     DW        = 8,
   parameter logic [DW-1:0]   CH_STEP   = 8'h40,
   parameter logic [DW-1:0]   CONST_VAL = 8'h80,
   parameter int unsigned     FRAMES    = 0
) (
   input  logic                 pclk,
   input  logic                 reset_n,
   input  logic                 run_test,
   input  logic                 stop_test,
   input  logic [1:0]           mode,
   output logic                 VSYNC,
   output logic                 HREF,
   output logic [NUM_CH*DW-1:0] D,
   output logic                 busy,
   output logic [15:0]          frame_cnt,
   output logic                 frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      VS,
      VFP,
      LINE,
      VBP
   } state_t;

   localparam logic [15:0] LastLine = 16'(V_ACTIVE - 1);
   localparam logic [15:0] Frames16 = 16'(FRAMES);

   state_t               state_q, state_d;
   logic [31:0]          cnt_q, cnt_d;
   logic [15:0]          line_q, line_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;
   logic                 stop_pend_q, stop_pend_d;
   logic [1:0]           mode_lat_q, mode_lat_d;

   logic                 run_q, stop_q;
   logic [1:0]           mode_q;

   logic                 vsync_q, vsync_d;
   logic                 href_q, href_d;
   logic [NUM_CH*DW-1:0] d_q, d_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;

   logic                 runComplete;
   logic [DW-1:0]        pixBase;

   // Control inputs are captured once before the FSM uses them, so a pulse
   // sampled on one edge takes effect on the next; VSYNC and busy therefore
   // rise one edge after run_test is seen.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         run_q  <= 1'b0;
         stop_q <= 1'b0;
         mode_q <= 2'd0;
      end else begin
         run_q  <= run_test;
         stop_q <= stop_test;
         mode_q <= mode;
      end
   end

   // A bounded run ends once the frame about to finish brings the count up
   // to FRAMES; FRAMES of zero means the run only ends on a stop request.
   assign runComplete = (FRAMES != 0) && ((frame_cnt_q + 16'd1) == Frames16);

   // Next-state logic. cnt counts cycles inside the current state (inside
   // the current line while in LINE) and restarts at zero on every state or
   // line change. A stop seen while busy is only remembered here; it is acted
   // on at the end of the frame so a frame is never cut short.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 32'd1;
      line_d      = line_q;
      frame_cnt_d = frame_cnt_q;
      stop_pend_d = stop_pend_q;
      mode_lat_d  = mode_lat_q;

      if ((state_q != IDLE) && stop_q) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            cnt_d = 32'd0;
            if (run_q) begin
               state_d     = VS;
               line_d      = 16'd0;
               frame_cnt_d = 16'd0;
               stop_pend_d = stop_q;
               mode_lat_d  = mode_q;
            end
         end
         VS: begin
            if (cnt_q == VSYNC_LEN - 1) begin
               state_d = VFP;
               cnt_d   = 32'd0;
            end
         end
         VFP: begin
            if (cnt_q == V_FRONT - 1) begin
               state_d = LINE;
               cnt_d   = 32'd0;
               line_d  = 16'd0;
            end
         end
         LINE: begin
            if (cnt_q == H_TOTAL - 1) begin
               cnt_d = 32'd0;
               if (line_q == LastLine) begin
                  state_d = VBP;
               end else begin
                  line_d = line_q + 16'd1;
               end
            end
         end
         VBP: begin
            if (cnt_q == V_BACK - 1) begin
               cnt_d       = 32'd0;
               frame_cnt_d = frame_cnt_q + 16'd1;
               if (stop_pend_q || runComplete) begin
                  state_d     = IDLE;
                  stop_pend_d = 1'b0;
               end else begin
                  state_d    = VS;
                  mode_lat_d = mode_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 32'd0;
         end
      endcase
   end

   // Pattern value for the byte about to be driven, before the per-channel
   // offset. The mode and frame count are stable for the whole frame, so the
   // registered copies can be used directly.
   always_comb begin
      pixBase = '0;
      case (mode_lat_q)
         2'd0:    pixBase = DW'(cnt_d);
         2'd1:    pixBase = DW'(line_d);
         2'd2:    pixBase = DW'(cnt_d) + DW'(frame_cnt_q);
         default: pixBase = CONST_VAL;
      endcase
   end

   // Output values are derived from the next state so that, once registered,
   // every output lines up exactly with the state it belongs to.
   always_comb begin
      vsync_d      = (state_d == VS);
      href_d       = (state_d == LINE) && (cnt_d < 2 * H_ACTIVE);
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == VBP) && (cnt_d == V_BACK - 1);
      d_d          = '0;
      if (href_d) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
`ifdef DVP_IMIT_LINE_TAG_EN
            if (cnt_d == 32'd0) begin
               d_d[k*DW +: DW] = DW'(line_d[15:8]);
            end else if (cnt_d == 32'd1) begin
               d_d[k*DW +: DW] = DW'(line_d[7:0]);
            end else begin
               d_d[k*DW +: DW] = pixBase + DW'(k) * CH_STEP;
            end
`else
            d_d[k*DW +: DW] = pixBase + DW'(k) * CH_STEP;
`endif
         end
      end
   end

   // State and output registers. Reset is asynchronous so that pulling
   // reset_n mid-frame silences the bus immediately.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= 32'd0;
         line_q       <= 16'd0;
         frame_cnt_q  <= 16'd0;
         stop_pend_q  <= 1'b0;
         mode_lat_q   <= 2'd0;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         d_q          <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         line_q       <= line_d;
         frame_cnt_q  <= frame_cnt_d;
         stop_pend_q  <= stop_pend_d;
         mode_lat_q   <= mode_lat_d;
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         d_q          <= d_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign VSYNC      = vsync_q;
   assign HREF       = href_q;
   assign D          = d_q;
   assign busy       = busy_q;
   assign frame_cnt  = frame_cnt_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dvp_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_dvp_stream_gen
//
// Directed bench for dvp_stream_gen using a small frame geometry
// (4 pixels/line, 12-cycle lines, 3 lines, 5+6 cycles before the first line,
// 7 cycles after the last), giving a 54-cycle frame. A second instance with
// FRAMES=2 covers the bounded-run behaviour. Inputs are driven and outputs
// sampled on the falling edge of pclk.
// ---------------------------------------------------------------------------
module tb_dvp_stream_gen;

   localparam int FramePeriod = 54;
   localparam int FirstHref   = 11;

   logic        pclk = 1'b0;
   logic        reset_n;
   logic        run_test;
   logic        stop_test;
   logic        run2;
   logic [1:0]  mode;

   logic        VSYNC, HREF, busy, frame_done;
   logic [15:0] D;
   logic [15:0] frame_cnt;

   logic        VSYNC2, HREF2, busy2, frame_done2;
   logic [15:0] D2;
   logic [15:0] frame_cnt2;

   int checks = 0;
   int errors = 0;

   dvp_stream_gen #(
      .H_ACTIVE(4), .H_TOTAL(12), .V_ACTIVE(3), .VSYNC_LEN(5), .V_FRONT(6),
      .V_BACK(7), .NUM_CH(2), .DW(8), .CH_STEP(8'h40), .CONST_VAL(8'h80),
      .FRAMES(0)
   ) dut (
      .pclk(pclk), .reset_n(reset_n), .run_test(run_test), .stop_test(stop_test),
      .mode(mode), .VSYNC(VSYNC), .HREF(HREF), .D(D), .busy(busy),
      .frame_cnt(frame_cnt), .frame_done(frame_done)
   );

   dvp_stream_gen #(
      .H_ACTIVE(4), .H_TOTAL(12), .V_ACTIVE(3), .VSYNC_LEN(5), .V_FRONT(6),
      .V_BACK(7), .NUM_CH(2), .DW(8), .CH_STEP(8'h40), .CONST_VAL(8'h80),
      .FRAMES(2)
   ) dut2 (
      .pclk(pclk), .reset_n(reset_n), .run_test(run2), .stop_test(stop_test),
      .mode(mode), .VSYNC(VSYNC2), .HREF(HREF2), .D(D2), .busy(busy2),
      .frame_cnt(frame_cnt2), .frame_done(frame_done2)
   );

   // Free-running pixel clock, 10 time units per cycle.
   always #5 pclk = ~pclk;

   // Safety net so the run always ends even if the design never goes idle.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected byte for channel k at byte b of line l, written straight from
   // the pattern definitions.
   function automatic logic [7:0] expByte(input int md, input int b, input int l,
                                          input int k, input int fc);
      int v;
`ifdef DVP_IMIT_LINE_TAG_EN
      if (b == 0) return 8'((l >> 8) & 255);
      if (b == 1) return 8'(l & 255);
`endif
      case (md)
         0:       v = b;
         1:       v = l;
         2:       v = b + fc;
         default: v = 128;
      endcase
      v = v + k * 64;
      return 8'(v & 255);
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge pclk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issue a run (optionally with a simultaneous stop) from idle and leave
   // the bench at the first VSYNC cycle of the new frame.
   task automatic applyStimulus(input logic [1:0] md, input logic withStop);
      mode      = md;
      run_test  = 1'b1;
      stop_test = withStop;
      tick(1);
      run_test  = 1'b0;
      stop_test = 1'b0;
      checkOutput("startLatencyVsync", 32'(VSYNC), 32'd0);
      checkOutput("startLatencyBusy", 32'(busy), 32'd0);
      tick(1);
      checkOutput("startVsync", 32'(VSYNC), 32'd1);
      checkOutput("startBusy", 32'(busy), 32'd1);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   initial begin
      int fdCount;
      int vsCount;

      reset_n   = 1'b0;
      run_test  = 1'b0;
      stop_test = 1'b0;
      run2      = 1'b0;
      mode      = 2'd0;

      // Reset state.
      tick(2);
      checkOutput("rstVsync", 32'(VSYNC), 32'd0);
      checkOutput("rstHref", 32'(HREF), 32'd0);
      checkOutput("rstD", 32'(D), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstFrameCnt", 32'(frame_cnt), 32'd0);
      checkOutput("rstFrameDone", 32'(frame_done), 32'd0);
      reset_n = 1'b1;
      tick(2);
      checkOutput("idleBusy", 32'(busy), 32'd0);

      // Ramp frame, checked cycle by cycle from the VSYNC rise.
      $display("[TB] ramp timing");
      applyStimulus(2'd0, 1'b0);
      for (int c = 0; c < FramePeriod; c++) begin
         automatic int          ln      = (c - FirstHref) / 12;
         automatic int          lc      = (c - FirstHref) % 12;
         automatic logic        inLine  = (c >= FirstHref) && (c < FirstHref + 36);
         automatic logic        expHref = inLine && (lc < 8);
         automatic logic [15:0] expD    = expHref ?
            {expByte(0, lc, ln, 1, 0), expByte(0, lc, ln, 0, 0)} : 16'h0000;
         checkOutput("rampVsync", 32'(VSYNC), 32'(c < 5));
         checkOutput("rampHref", 32'(HREF), 32'(expHref));
         checkOutput("rampD", 32'(D), 32'(expD));
         checkOutput("rampFrameDone", 32'(frame_done), 32'(c == FramePeriod - 1));
         checkOutput("rampFrameCnt", 32'(frame_cnt), 32'd0);
         tick(1);
      end
      checkOutput("rampNextVsync", 32'(VSYNC), 32'd1);
      checkOutput("rampNextFrameCnt", 32'(frame_cnt), 32'd1);

      // Stop requested during line 1 of a fresh run.
      $display("[TB] stop mid-frame");
      doReset();
      applyStimulus(2'd0, 1'b0);
      tick(25);
      checkOutput("stopLine1Href", 32'(HREF), 32'd1);
      stop_test = 1'b1;
      tick(1);
      stop_test = 1'b0;
      tick(27);
      checkOutput("stopFrameDone", 32'(frame_done), 32'd1);
      checkOutput("stopBusyLast", 32'(busy), 32'd1);
      tick(1);
      checkOutput("stopBusyFall", 32'(busy), 32'd0);
      checkOutput("stopFrameCnt", 32'(frame_cnt), 32'd1);
      checkOutput("stopFrameDoneOff", 32'(frame_done), 32'd0);
      vsCount = 0;
      for (int i = 0; i < 60; i++) begin
         if (VSYNC) vsCount++;
         tick(1);
      end
      checkOutput("stopNoVsync", 32'(vsCount), 32'd0);

      // Bounded run on the FRAMES=2 instance.
      $display("[TB] FRAMES=2 run");
      run2 = 1'b1;
      tick(1);
      run2 = 1'b0;
      fdCount = 0;
      for (int i = 0; i < 180; i++) begin
         if (frame_done2) fdCount++;
         tick(1);
      end
      checkOutput("frames2DoneCount", 32'(fdCount), 32'd2);
      checkOutput("frames2FrameCnt", 32'(frame_cnt2), 32'd2);
      checkOutput("frames2Busy", 32'(busy2), 32'd0);

      // Mode 2 across two frames, with an ignored mid-frame run_test.
      $display("[TB] mode 2 scroll");
      applyStimulus(2'd2, 1'b0);
      checkOutput("mode2CntCleared", 32'(frame_cnt), 32'd0);
      tick(FirstHref);
      checkOutput("mode2F0Ch0", 32'(D[7:0]), 32'(expByte(2, 0, 0, 0, 0)));
      checkOutput("mode2F0Ch1", 32'(D[15:8]), 32'(expByte(2, 0, 0, 1, 0)));
      tick(FramePeriod);
      checkOutput("mode2F1Ch0", 32'(D[7:0]), 32'(expByte(2, 0, 0, 0, 1)));
      checkOutput("mode2F1Ch1", 32'(D[15:8]), 32'(expByte(2, 0, 0, 1, 1)));
      checkOutput("mode2F1Byte2Ch0Pre", 32'(frame_cnt), 32'd1);
      tick(2);
      checkOutput("mode2F1Byte2Ch0", 32'(D[7:0]), 32'h03);
      tick(7);
      run_test = 1'b1;
      tick(1);
      run_test = 1'b0;
      tick(32);
      checkOutput("ignoredRunFrameDone", 32'(frame_done), 32'd1);
      checkOutput("ignoredRunFrameCnt", 32'(frame_cnt), 32'd1);
      tick(1);
      checkOutput("ignoredRunNextVsync", 32'(VSYNC), 32'd1);
      checkOutput("ignoredRunNoClear", 32'(frame_cnt), 32'd2);
      stop_test = 1'b1;
      tick(1);
      stop_test = 1'b0;
      for (int i = 0; i < 200 && busy; i++) tick(1);
      checkOutput("mode2StopIdle", 32'(busy), 32'd0);
      checkOutput("mode2StopFrameCnt", 32'(frame_cnt), 32'd3);

      // Run and stop together from idle: exactly one frame.
      $display("[TB] simultaneous run and stop");
      applyStimulus(2'd0, 1'b1);
      fdCount = 0;
      for (int i = 0; i < 150; i++) begin
         if (frame_done) fdCount++;
         tick(1);
      end
      checkOutput("simulDoneCount", 32'(fdCount), 32'd1);
      checkOutput("simulBusy", 32'(busy), 32'd0);
      checkOutput("simulFrameCnt", 32'(frame_cnt), 32'd1);

      // Asynchronous reset in the middle of a line, then a clean restart.
      $display("[TB] reset mid-line");
      applyStimulus(2'd0, 1'b0);
      tick(FramePeriod + 15);
      checkOutput("preRstHref", 32'(HREF), 32'd1);
      checkOutput("preRstFrameCnt", 32'(frame_cnt), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midRstVsync", 32'(VSYNC), 32'd0);
      checkOutput("midRstHref", 32'(HREF), 32'd0);
      checkOutput("midRstD", 32'(D), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstFrameCnt", 32'(frame_cnt), 32'd0);
      @(negedge pclk);
      reset_n = 1'b1;
      applyStimulus(2'd0, 1'b0);
      tick(FirstHref + 24);
      checkOutput("line2Byte0",
                  32'(D), 32'({expByte(0, 0, 2, 1, 0), expByte(0, 0, 2, 0, 0)}));
      tick(1);
      checkOutput("line2Byte1",
                  32'(D), 32'({expByte(0, 1, 2, 1, 0), expByte(0, 1, 2, 0, 0)}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dvp_stream_gen.md
# dvp_stream_gen

Synthesisable, parametrised DVP camera imitator generating VSYNC/HREF timing and YCbCr422 byte streams for NUM_CH sensors sharing one timing. It replaces file-driven simulation imitators with on-chip pattern sources, so HDR merge, capture and DDR paths can be exercised in hardware. It sits in place of the sensor pads, ahead of the DVP capture blocks.

## Interface
Parameters:
- H_ACTIVE, 1280: pixels per line; each line carries 2*H_ACTIVE bytes.
- H_TOTAL, 5688: pclk cycles per line, active plus blanking; must be > 2*H_ACTIVE.
- V_ACTIVE, 720: active lines per frame.
- VSYNC_LEN, 11376: VSYNC high duration in pclk.
- V_FRONT, 976: pclk from VSYNC fall to first HREF rise.
- V_BACK, 5688: blank pclk after the last line before frame end.
- NUM_CH, 2: number of output channels, 1..4.
- DW, 8: data width per channel.
- CH_STEP, 8'h40: per-channel data offset; channel k adds k*CH_STEP mod 2^DW.
- CONST_VAL, 8'h80: mode-3 data value.
- FRAMES, 0: frames per run; 0 means run until stopped.

Ports:
- pclk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- run_test  in  1  one-cycle start pulse.
- stop_test  in  1  one-cycle graceful stop request.
- mode  in  2  pattern select: 0 ramp, 1 line index, 2 frame-scrolled ramp, 3 constant.
- VSYNC  out  1  frame sync, active high.
- HREF  out  1  line valid.
- D  out  NUM_CH*DW  channel k occupies D[k*DW +: DW].
- busy  out  1  high while not IDLE.
- frame_cnt  out  16  frames completed since last run_test; wraps at 2^16.
- frame_done  out  1  one-cycle pulse at end of each frame.

## Operation
- States: IDLE, VS (VSYNC_LEN cycles), VFP (V_FRONT), LINE (V_ACTIVE lines of H_TOTAL cycles), VBP (V_BACK).
- Transitions:
  - IDLE to VS on run_test.
  - VS to VFP to LINE to VBP, each after its count expires.
  - VBP end: frame_done pulses and frame_cnt increments. Go to IDLE if stop_pending, or if FRAMES≠0 and this run has completed FRAMES frames; otherwise go to VS.
- In LINE: HREF=1 for the first 2*H_ACTIVE cycles of each line (byte index b=0..2*H_ACTIVE-1), else 0.
- mode is latched on entry to VS and held for the frame.
- Data for byte b, line l, channel k, before truncation to DW bits:
  - mode 0: b.
  - mode 1: l.
  - mode 2: b + frame_cnt.
  - mode 3: CONST_VAL.
  - Each value then adds k*CH_STEP.
- D=0 whenever HREF=0.
- run_test while busy is ignored.
- stop_test while busy sets stop_pending; the current frame always completes. stop_test in IDLE is ignored.
- run_test and stop_test in the same IDLE cycle: the run starts, stop_pending is set, and exactly one frame is produced.
- run_test clears frame_cnt to 0.

## Timing
- Reset values: VSYNC=0, HREF=0, D=0, busy=0, frame_cnt=0, frame_done=0, stop_pending=0, state IDLE.
- All outputs are registered.
- run_test sampled at edge n gives VSYNC=1 and busy=1 from edge n+1.
- First HREF rise occurs VSYNC_LEN+V_FRONT cycles after the VSYNC rise.
- Frame period = VSYNC_LEN + V_FRONT + V_ACTIVE*H_TOTAL + V_BACK cycles. Back-to-back frames have no gap.
- D is valid in the same cycle as HREF=1.
- frame_done is high in the last VBP cycle. frame_cnt updates on the following edge, together with the VS or IDLE entry.
- busy falls on the same edge as IDLE entry.
- Asserting reset mid-frame returns all outputs to reset values immediately.

## Configuration
- DVP_IMIT_LINE_TAG_EN defined: bytes b=0 and b=1 of every line carry l[15:8] and l[7:0] respectively, identical on all channels. These bytes ignore mode and CH_STEP. Bytes from b=2 onward follow the pattern.
- DVP_IMIT_LINE_TAG_EN undefined: every byte follows the pattern.

## Test plan
Bench parameters: H_ACTIVE=4, H_TOTAL=12, V_ACTIVE=3, VSYNC_LEN=5, V_FRONT=6, V_BACK=7, NUM_CH=2, CH_STEP=8'h40, FRAMES=0. Frame period is 54 cycles.

- Ramp timing: reset, then mode=0 and run_test. Required: VSYNC high 5 cycles, first HREF 11 cycles after VSYNC rise, 3 HREF bursts of 8 cycles spaced 12 cycles apart. ch0 D=00..07 and ch1 D=40..47 in each burst. frame_done every 54 cycles.
- Stop mid-frame: stop_test during line 1. Required: the frame completes, frame_done=1, frame_cnt=1, busy falls the following cycle, no further VSYNC.
- FRAMES=2 run: required exactly 2 frame_done pulses, frame_cnt=2, then IDLE.
- Mode 2: over frames 0 and 1, required ch0 first byte 00 then 01; ch1 first byte 40 then 41.
- Simultaneous run_test and stop_test in IDLE: required exactly one frame. A run_test issued mid-frame is ignored, and frame_cnt is not cleared.
- Reset asserted mid-LINE: required VSYNC=HREF=D=busy=0 immediately. A later run_test restarts cleanly. With DVP_IMIT_LINE_TAG_EN, line 2 begins with bytes 00, 02 on both channels.
